aes_core_sequencer: RTL and testbench
=====================================

# aes_core_sequencer

Sequencer that owns the AES core's control handshake. It accepts a key-load request and then a stream of 128-bit blocks over valid/ready interfaces. For each block it issues the core `init`/`next` pulses, waits for `ready`/`result_valid`, and presents each result on a valid/ready output. It sits between the host-side register front end and the AES core, so the front end no longer hand-pulses `init`/`next`.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 1023: maximum cycles to wait for a core response before aborting.
- `TO_W`, default 10: width of the timeout counter. Must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous active-low reset.
- `key_load` in 1: request key expansion, sampled with the four key-side inputs below.
- `key_in` in 256: key. 128-bit keys occupy [255:128].
- `keylen_in` in 1: 0 = AES-128, 1 = AES-256.
- `encdec_in` in 1: 1 = encrypt, 0 = decrypt.
- `iv_in` in 128: chaining IV. Used only when `AES_SEQ_CBC_EN` is defined.
- `blk_valid` in 1: input block valid.
- `blk_ready` out 1: sequencer accepts a block.
- `blk_data` in 128: input block.
- `res_valid` out 1: result valid.
- `res_ready` in 1: downstream accepts the result.
- `res_data` out 128: result block.
- `core_encdec`, `core_keylen` out 1: registered core configuration.
- `core_key` out 256: registered key.
- `core_block` out 128: registered block.
- `core_init`, `core_next` out 1: one-cycle start pulses.
- `core_ready` in 1: core idle.
- `core_valid` in 1: core result valid.
- `core_result` in 128: core result.
- `key_ok` out 1: a key is expanded and usable.
- `busy` out 1: state is anything other than IDLE or KEYED.
- `err` out 1: sticky error flag.

## Operation
States and transitions:
- IDLE → KINIT on `key_load`.
- KINIT: `core_init`=1 for one cycle → KWAIT.
- KWAIT: the first cycle is a blanking cycle. After that, `core_ready`=1 → KEYED with `key_ok`=1. A timeout → IDLE.
- KEYED: `blk_ready`=1.
  - `blk_valid & blk_ready` → BSTART, with the block latched into `core_block`.
  - `key_load` → KINIT, with `key_ok` cleared.
  - If `key_load` and `blk_valid` are both high in the same cycle, `key_load` wins and the block is not accepted.
- BSTART: `core_next`=1 for one cycle → BWAIT.
- BWAIT: blanking cycle first. After that, `core_valid & core_ready` → OUT with `core_result` captured. A timeout → IDLE.
- OUT: `res_valid`=1 until `res_valid & res_ready` → KEYED.

Input sampling:
- `key_in`, `keylen_in`, `encdec_in` and `iv_in` are registered on the accepted `key_load`. They are held stable until the next accepted `key_load`.

Error cases:
- `key_load` in any state other than IDLE or KEYED is ignored and sets `err`.
- `blk_valid` while `key_ok`=0 is never accepted, because `blk_ready`=0.
- On timeout: set `err`, clear `key_ok`, and assert `core_init`=`core_next`=0.
- `err` clears on the next accepted `key_load`.

Timeout counter:
- Resets on entry to KWAIT and BWAIT and increments each cycle in those states.
- A timeout fires when the count equals `TIMEOUT_CYCLES`.

## Timing
- Reset values: all outputs 0, state IDLE, chain register 0.
- `core_*` outputs are registered with no combinational path from any input.
- Block accepted at cycle T:
  - `core_next` is high at T+1.
  - `core_result` is captured in the cycle that `core_valid & core_ready` is seen.
  - `res_valid` rises the following cycle.
- Minimum block-to-block spacing is 4 cycles plus core latency, assuming `res_ready` is held at 1.
- `res_data` is stable while `res_valid`=1.
- `core_init` and `core_next` are never high in the same cycle.
- `rst_n` low mid-operation aborts immediately. Any core computation in flight is discarded.

## Configuration
- `AES_SEQ_CBC_EN` defined (CBC chaining):
  - The chain register loads `iv_in` on `key_load`.
  - Encrypt: `core_block` = blk ^ chain; on capture, chain ← result; `res_data` = result.
  - Decrypt: `core_block` = blk; `res_data` = result ^ chain; chain ← the accepted blk.
- `AES_SEQ_CBC_EN` undefined (ECB):
  - `iv_in` is ignored.
  - `core_block` = blk and `res_data` = result.
  - No chain register is built.

## Test plan
- **Reset:** `rst_n`=0 mid-BWAIT → all outputs 0 and state IDLE; `blk_ready`=0 after release.
- **ECB encrypt, AES-128:**
  - Stimulus: key 000102030405060708090a0b0c0d0e0f, encrypt, block 00112233445566778899aabbccddeeff.
  - Expected: `res_data`=69c4e0d86a7b0430d8cdb78070b4c55a; exactly one `core_init` and one `core_next` pulse.
- **Backpressure:** hold `res_ready`=0 for 20 cycles → `res_valid` held, `res_data` stable, `blk_ready`=0 throughout; result transfers on the first cycle with `res_ready`=1.
- **Timeout:** a core model that never raises `core_ready` after init, with `TIMEOUT_CYCLES`=15 → `err`=1 and `key_ok`=0; a subsequent `key_load` clears `err`.
- **Illegal key_load:** `key_load` during BWAIT → ignored and `err`=1; the current block completes with its correct result.
- **CBC (macro defined):**
  - Encrypt two identical blocks with IV 0 → the two ciphertexts differ, and the second equals E(blk ^ ct1).
  - Decrypting both returns the original plaintext.

Source files
------------

// File: rtl/aes_core_sequencer.sv
// aes_core_sequencer: owns the AES core init/next handshake. Accepts a key
// load, then a stream of 128-bit blocks over valid/ready, pulses the core,
// waits for its response (with timeout) and presents results over valid/ready.
// Optional CBC chaining is built when AES_SEQ_CBC_EN is defined; the default
// build is plain ECB with no chain register.
module aes_core_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 1023,
    parameter int unsigned TO_W           = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         key_load,
    input  logic [255:0] key_in,
    input  logic         keylen_in,
    input  logic         encdec_in,
    input  logic [127:0] iv_in,
    input  logic         blk_valid,
    output logic         blk_ready,
    input  logic [127:0] blk_data,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [127:0] res_data,
    output logic         core_encdec,
    output logic         core_keylen,
    output logic [255:0] core_key,
    output logic [127:0] core_block,
    output logic         core_init,
    output logic         core_next,
    input  logic         core_ready,
    input  logic         core_valid,
    input  logic [127:0] core_result,
    output logic         key_ok,
    output logic         busy,
    output logic         err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_KINIT,
        S_KWAIT,
        S_KEYED,
        S_BSTART,
        S_BWAIT,
        S_OUT
    } state_t;

    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES);

    state_t          state;
    state_t          state_nx;
    logic [TO_W-1:0] to_cnt;
    logic            blank;
    logic            in_wait;
    logic            in_wait_nx;
    logic            key_take;
    logic            key_bad;
    logic            key_done;
    logic            blk_take;
    logic            capture;
    logic            timeout;

`ifdef AES_SEQ_CBC_EN
    logic [127:0] chain;
`else
    logic unused_iv;
    assign unused_iv = ^iv_in;
`endif

    // The first cycle of each wait state ignores the core so that stale
    // ready/valid from before the start pulse cannot be mistaken for a response.
    assign blank      = (to_cnt == '0);
    assign in_wait    = (state == S_KWAIT) || (state == S_BWAIT);
    assign in_wait_nx = (state_nx == S_KWAIT) || (state_nx == S_BWAIT);

    // A key load in KEYED takes priority, so the block side is not offered.
    assign blk_ready = (state == S_KEYED) && !key_load;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decode and single-cycle event strobes.
    always_comb begin
        state_nx = state;
        key_take = 1'b0;
        key_bad  = 1'b0;
        key_done = 1'b0;
        blk_take = 1'b0;
        capture  = 1'b0;
        timeout  = 1'b0;
        case (state)
            S_IDLE: begin
                if (key_load) begin
                    key_take = 1'b1;
                    state_nx = S_KINIT;
                end
            end
            S_KINIT: begin
                key_bad  = key_load;
                state_nx = S_KWAIT;
            end
            S_KWAIT: begin
                key_bad = key_load;
                if (!blank && core_ready) begin
                    key_done = 1'b1;
                    state_nx = S_KEYED;
                end else if (to_cnt == TO_LIMIT) begin
                    timeout  = 1'b1;
                    state_nx = S_IDLE;
                end
            end
            S_KEYED: begin
                if (key_load) begin
                    key_take = 1'b1;
                    state_nx = S_KINIT;
                end else if (blk_valid) begin
                    blk_take = 1'b1;
                    state_nx = S_BSTART;
                end
            end
            S_BSTART: begin
                key_bad  = key_load;
                state_nx = S_BWAIT;
            end
            S_BWAIT: begin
                key_bad = key_load;
                if (!blank && core_valid && core_ready) begin
                    capture  = 1'b1;
                    state_nx = S_OUT;
                end else if (to_cnt == TO_LIMIT) begin
                    timeout  = 1'b1;
                    state_nx = S_IDLE;
                end
            end
            S_OUT: begin
                key_bad = key_load;
                if (res_ready) begin
                    state_nx = S_KEYED;
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // Registered outputs, key/block latches, timeout counter and chaining.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_init   <= 1'b0;
            core_next   <= 1'b0;
            core_key    <= '0;
            core_keylen <= 1'b0;
            core_encdec <= 1'b0;
            core_block  <= '0;
            res_data    <= '0;
            res_valid   <= 1'b0;
            key_ok      <= 1'b0;
            busy        <= 1'b0;
            err         <= 1'b0;
            to_cnt      <= '0;
`ifdef AES_SEQ_CBC_EN
            chain       <= '0;
`endif
        end else begin
            // Pulses and status are decoded from the next state so they are
            // flops aligned with the state they describe.
            core_init <= (state_nx == S_KINIT);
            core_next <= (state_nx == S_BSTART);
            res_valid <= (state_nx == S_OUT);
            busy      <= !((state_nx == S_IDLE) || (state_nx == S_KEYED));

            if (in_wait_nx && (state_nx != state)) begin
                to_cnt <= '0;
            end else if (in_wait) begin
                to_cnt <= to_cnt + TO_W'(1);
            end

            if (key_take) begin
                core_key    <= key_in;
                core_keylen <= keylen_in;
                core_encdec <= encdec_in;
                err         <= 1'b0;
                key_ok      <= 1'b0;
`ifdef AES_SEQ_CBC_EN
                chain       <= iv_in;
`endif
            end else if (key_bad || timeout) begin
                err <= 1'b1;
            end

            if (timeout) begin
                key_ok <= 1'b0;
            end else if (key_done) begin
                key_ok <= 1'b1;
            end

            if (blk_take) begin
`ifdef AES_SEQ_CBC_EN
                core_block <= core_encdec ? (blk_data ^ chain) : blk_data;
`else
                core_block <= blk_data;
`endif
            end

            // In decrypt mode core_block still holds the ciphertext, which
            // becomes the next chain value once this result is unmasked.
            if (capture) begin
`ifdef AES_SEQ_CBC_EN
                if (core_encdec) begin
                    res_data <= core_result;
                    chain    <= core_result;
                end else begin
                    res_data <= core_result ^ chain;
                    chain    <= core_block;
                end
`else
                res_data <= core_result;
`endif
            end
        end
    end

endmodule

// File: tb/tb_aes_core_sequencer.sv
`timescale 1ns/1ps
// Self-checking bench for aes_core_sequencer with a behavioural AES core
// stand-in (keyed invertible mix plus the FIPS-197 AES-128 vector).
module tb_aes_core_sequencer;

    localparam int unsigned TO_CYC = 15;
    localparam logic [127:0] KAT_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] KAT_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KAT_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] MIXC    = 128'h5a5a_c3c3_0f0f_9696_a5a5_3c3c_f0f0_6969;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         key_load = 1'b0;
    logic [255:0] key_in = '0;
    logic         keylen_in = 1'b0;
    logic         encdec_in = 1'b0;
    logic [127:0] iv_in = '0;
    logic         blk_valid = 1'b0;
    logic         blk_ready;
    logic [127:0] blk_data = '0;
    logic         res_valid;
    logic         res_ready = 1'b1;
    logic [127:0] res_data;
    logic         core_encdec, core_keylen;
    logic [255:0] core_key;
    logic [127:0] core_block;
    logic         core_init, core_next;
    logic         core_ready, core_valid;
    logic [127:0] core_result;
    logic         key_ok, busy, err;

    always #5 clk = ~clk;

    aes_core_sequencer #(.TIMEOUT_CYCLES(TO_CYC), .TO_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .key_load(key_load), .key_in(key_in),
        .keylen_in(keylen_in), .encdec_in(encdec_in), .iv_in(iv_in),
        .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .core_encdec(core_encdec), .core_keylen(core_keylen), .core_key(core_key),
        .core_block(core_block), .core_init(core_init), .core_next(core_next),
        .core_ready(core_ready), .core_valid(core_valid), .core_result(core_result),
        .key_ok(key_ok), .busy(busy), .err(err)
    );

    int errors = 0;
    int checks = 0;

    // Stand-in cipher: AES-128 known-answer pair, otherwise a keyed rotate/xor.
    function automatic logic [127:0] cipher(input logic [255:0] k256, input logic kl,
                                            input logic enc, input logic [127:0] b);
        logic [127:0] k, t;
        k = kl ? (k256[255:128] ^ k256[127:0]) : k256[255:128];
        if (!kl && k256[255:128] == KAT_KEY && enc && b == KAT_PT) return KAT_CT;
        if (!kl && k256[255:128] == KAT_KEY && !enc && b == KAT_CT) return KAT_PT;
        if (enc) begin
            t = b ^ k;
            return {t[120:0], t[127:121]} ^ MIXC;
        end
        t = b ^ MIXC;
        return {t[6:0], t[127:7]} ^ k;
    endfunction

    // Core model: drops ready on a start pulse, responds after lat_cfg cycles.
    int           lat_cfg = 3;
    bit           hang = 1'b0;
    int           busy_cnt;
    bit           op_next;
    logic [127:0] snap;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_ready  <= 1'b1;
            core_valid  <= 1'b0;
            core_result <= '0;
            busy_cnt    <= 0;
            op_next     <= 1'b0;
            snap        <= '0;
        end else if (core_init) begin
            core_ready <= 1'b0;
            core_valid <= 1'b0;
            busy_cnt   <= lat_cfg;
            op_next    <= 1'b0;
        end else if (core_next) begin
            core_ready <= 1'b0;
            core_valid <= 1'b0;
            busy_cnt   <= lat_cfg;
            op_next    <= 1'b1;
            snap       <= cipher(core_key, core_keylen, core_encdec, core_block);
        end else if (busy_cnt > 0 && !(hang && !op_next)) begin
            busy_cnt <= busy_cnt - 1;
            if (busy_cnt == 1) begin
                core_ready <= 1'b1;
                if (op_next) begin
                    core_valid  <= 1'b1;
                    core_result <= snap;
                end
            end
        end
    end

    // Pulse counting and init/next overlap detection.
    int n_init = 0;
    int n_next = 0;
    bit overlap = 1'b0;
    always @(negedge clk) begin
        if (core_init) n_init++;
        if (core_next) n_next++;
        if (core_init && core_next) overlap = 1'b1;
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model state: key configuration and chain value.
    logic [255:0] m_key;
    logic         m_kl, m_enc;
    logic [127:0] m_chain;

    task automatic model_step(input logic [127:0] b, output logic [127:0] cb,
                              output logic [127:0] r);
`ifdef AES_SEQ_CBC_EN
        if (m_enc) begin
            cb = b ^ m_chain;
            r = cipher(m_key, m_kl, 1'b1, cb);
            m_chain = r;
        end else begin
            cb = b;
            r = cipher(m_key, m_kl, 1'b0, b) ^ m_chain;
            m_chain = b;
        end
`else
        cb = b;
        r = cipher(m_key, m_kl, m_enc, b);
`endif
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " res_valid"}, res_valid, 0);
        chk({tag, " blk_ready"}, blk_ready, 0);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " err"}, err, 0);
        chk({tag, " key_ok"}, key_ok, 0);
        chk({tag, " core_init/next"}, {core_init, core_next}, 0);
        chk({tag, " core_cfg"}, {core_keylen, core_encdec}, 0);
        chk({tag, " core_key"}, core_key, 0);
        chk({tag, " core_block"}, core_block, 0);
        chk({tag, " res_data"}, res_data, 0);
    endtask

    // Called just after a negedge; returns at the negedge in KINIT.
    task automatic load_key(input logic [255:0] k, input logic kl, input logic enc,
                            input logic [127:0] iv, input bit expect_ok);
        int n;
        @(negedge clk);
        key_load = 1'b1; key_in = k; keylen_in = kl; encdec_in = enc; iv_in = iv;
        @(negedge clk);
        key_load = 1'b0;
        m_key = k; m_kl = kl; m_enc = enc; m_chain = iv;
        if (expect_ok) begin
            n = 0;
            while (!key_ok && n < 100) begin
                @(negedge clk);
                n++;
            end
            chk("key_ok after load", key_ok, 1);
            chk("err after load", err, 0);
        end
    endtask

    // Offers a block; returns at the negedge after acceptance (core_next cycle).
    task automatic send_block(input logic [127:0] b, output logic [127:0] exp);
        int n;
        logic [127:0] cb;
        blk_valid = 1'b1;
        blk_data = b;
        n = 0;
        while (!blk_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("blk accepted in bound", (n < 100), 1);
        model_step(b, cb, exp);
        @(negedge clk);
        blk_valid = 1'b0;
        chk("core_next at T+1", core_next, 1);
        chk("core_block latched", core_block, cb);
    endtask

    task automatic get_result(input logic [127:0] exp, input string tag,
                              output logic [127:0] got);
        int n;
        n = 0;
        while (!res_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        got = res_data;
        chk({tag, " res_valid"}, res_valid, 1);
        chk({tag, " res_data"}, res_data, exp);
        @(negedge clk);
        chk({tag, " res consumed"}, res_valid, 0);
    endtask

    initial begin
        logic [255:0] k;
        logic [127:0] b, e, got, d0, ct1, ct2;
        int i0, x0, n;

        // Reset state
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle blk_ready", blk_ready, 0);

        // Block offered without a key is never taken
        blk_valid = 1'b1; blk_data = KAT_PT;
        repeat (3) @(negedge clk);
        chk("no key no accept busy", busy, 0);
        blk_valid = 1'b0;

        // AES-128 known answer, pulse counts
        i0 = n_init; x0 = n_next;
        load_key({KAT_KEY, 128'h0}, 1'b0, 1'b1, '0, 1);
        send_block(KAT_PT, e);
        get_result(KAT_CT, "kat", got);
        chk("kat init pulses", n_init - i0, 1);
        chk("kat next pulses", n_next - x0, 1);

        // Randomized keys, modes and latencies
        for (int t = 0; t < 6; t++) begin
            k = {$urandom(), $urandom(), $urandom(), $urandom(),
                 $urandom(), $urandom(), $urandom(), $urandom()};
            lat_cfg = $urandom_range(1, 6);
            load_key(k, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     {$urandom(), $urandom(), $urandom(), $urandom()}, 1);
            for (int j = 0; j < 3; j++) begin
                lat_cfg = $urandom_range(1, 8);
                b = {$urandom(), $urandom(), $urandom(), $urandom()};
                send_block(b, e);
                get_result(e, "rand", got);
            end
        end

        // Backpressure: result held 20 cycles
        res_ready = 1'b0;
        b = {$urandom(), $urandom(), $urandom(), $urandom()};
        send_block(b, e);
        n = 0;
        while (!res_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        d0 = res_data;
        chk("bp data", d0, e);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk("bp res_valid held", res_valid, 1);
            chk("bp res_data stable", res_data, e);
            chk("bp blk_ready low", blk_ready, 0);
        end
        res_ready = 1'b1;
        @(negedge clk);
        chk("bp transfer", res_valid, 0);
        chk("bp back to keyed", blk_ready, 1);

        // Illegal key_load during BWAIT
        lat_cfg = 10;
        b = {$urandom(), $urandom(), $urandom(), $urandom()};
        send_block(b, e);
        repeat (2) @(negedge clk);
        key_load = 1'b1; key_in = ~m_key;
        @(negedge clk);
        key_load = 1'b0;
        chk("illegal err", err, 1);
        chk("illegal busy", busy, 1);
        chk("illegal key kept", core_key, m_key);
        get_result(e, "illegal", got);
        chk("illegal key_ok kept", key_ok, 1);

        // Timeout on key expansion
        hang = 1'b1;
        load_key(256'h1234, 1'b0, 1'b1, '0, 0);
        n = 0;
        while (!err && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("timeout cycle", n, TO_CYC + 2);
        chk("timeout err", err, 1);
        chk("timeout key_ok", key_ok, 0);
        chk("timeout busy", busy, 0);
        hang = 1'b0;
        lat_cfg = 4;
        load_key(256'h5678, 1'b1, 1'b0, '0, 1);
        chk("err cleared", err, 0);

        // Reset mid-BWAIT
        lat_cfg = 20;
        b = {$urandom(), $urandom(), $urandom(), $urandom()};
        send_block(b, e);
        repeat (3) @(negedge clk);
        chk("pre-reset busy", busy, 1);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("mid reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post reset blk_ready", blk_ready, 0);
        chk("post reset busy", busy, 0);

`ifdef AES_SEQ_CBC_EN
        // CBC round trip with IV 0 and two identical blocks
        lat_cfg = 3;
        k = {$urandom(), $urandom(), $urandom(), $urandom(), 128'h0};
        b = {$urandom(), $urandom(), $urandom(), $urandom()};
        load_key(k, 1'b0, 1'b1, '0, 1);
        send_block(b, e);
        get_result(e, "cbc ct1", ct1);
        send_block(b, e);
        get_result(e, "cbc ct2", ct2);
        chk("cbc cts differ", (ct1 != ct2), 1);
        chk("cbc ct2 chained", ct2, cipher(k, 1'b0, 1'b1, b ^ ct1));
        load_key(k, 1'b0, 1'b0, '0, 1);
        send_block(ct1, e);
        get_result(b, "cbc pt1", got);
        send_block(ct2, e);
        get_result(b, "cbc pt2", got);
`endif

        chk("init/next never overlap", overlap, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
